// File: rtl/data_memory_mmio.sv
// ---------------------------------------------------------------------------
// data_memory_mmio
//   Single-cycle data memory with a small memory-mapped peripheral window.
//   Addresses with [31:16] == 16'hFFFF hit the MMIO registers. Every other
//   address hits a word-addressed RAM that aliases modulo DEPTH_WORDS*4 bytes.
//   Reads are combinational. Writes commit at the rising clk edge. There are
//   no wait states and no handshake.
//
//   MMIO map (offset = address[15:0]):
//     0x0000 COUNT    free-running up counter; a write loads it
//     0x0004 COMPARE  match value
//     0x0008 STATUS   bit0 = match flag, write-1-to-clear
//     0x000C GPIO     bits [7:0] drive gpio_out; upper bits read 0
//     others          read 0, writes ignored
//
//   Build option: define DATA_MEMORY_MMIO_TIMER_EN to implement COUNT,
//   COMPARE and STATUS. Without it, those offsets read 0, writes to them are
//   dropped, and irq is tied low.
//
// Ports
//   clk           sole clock, rising edge
//   reset         asynchronous active-high reset (MMIO registers only)
//   WE            write enable
//   address       byte address
//   data_to_mem   write data
//   data_from_mem read data (combinational)
//   gpio_out      GPIO[7:0]
//   irq           STATUS[0]
// ---------------------------------------------------------------------------
module data_memory_mmio #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [31:0] address,
    input  logic [31:0] data_to_mem,
    output logic [31:0] data_from_mem,
    output logic [7:0]  gpio_out,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [15:0] OFF_COUNT   = 16'h0000;
    localparam logic [15:0] OFF_COMPARE = 16'h0004;
    localparam logic [15:0] OFF_STATUS  = 16'h0008;
    localparam logic [15:0] OFF_GPIO    = 16'h000C;

    logic [31:0] mem [DEPTH_WORDS];

    logic          is_mmio;
    logic [AW-1:0] ram_idx;
    logic [15:0]   mmio_off;
    logic          wr_mmio;

    assign is_mmio  = (address[31:16] == 16'hFFFF);
    assign ram_idx  = address[AW+1:2];
    assign mmio_off = address[15:0];
    assign wr_mmio  = WE && is_mmio;

    // RAM carries no reset, so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (WE && !is_mmio)
            mem[ram_idx] <= data_to_mem;
    end

    // ---------------- GPIO ----------------
    logic [7:0] gpio_q, gpio_d;

    always_comb begin
        gpio_d = gpio_q;
        if (wr_mmio && mmio_off == OFF_GPIO)
            gpio_d = data_to_mem[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) gpio_q <= 8'h00;
        else       gpio_q <= gpio_d;
    end

    assign gpio_out = gpio_q;

`ifdef DATA_MEMORY_MMIO_TIMER_EN
    // ---------------- Timer ----------------
    logic [31:0] count_q,   count_d;
    logic [31:0] compare_q, compare_d;
    logic        status_q,  status_d;
    logic        match;

    // Match uses the pre-edge COUNT and COMPARE, so a COMPARE write only
    // influences matching from the following edge.
    assign match = (count_q == compare_q);

    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        status_d  = status_q;
        if (wr_mmio && mmio_off == OFF_COUNT)
            count_d = data_to_mem;
        if (wr_mmio && mmio_off == OFF_COMPARE)
            compare_d = data_to_mem;
        // Set has priority over a simultaneous W1C.
        if (match)
            status_d = 1'b1;
        else if (wr_mmio && mmio_off == OFF_STATUS && data_to_mem[0])
            status_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= 32'h0000_0000;
            compare_q <= 32'hFFFF_FFFF;
            status_q  <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            status_q  <= status_d;
        end
    end

    assign irq = status_q;
`else
    assign irq = 1'b0;
`endif

    // ---------------- Read mux ----------------
    always_comb begin
        data_from_mem = 32'h0000_0000;
        if (is_mmio) begin
            case (mmio_off)
                OFF_GPIO:    data_from_mem = {24'h0, gpio_q};
`ifdef DATA_MEMORY_MMIO_TIMER_EN
                OFF_COUNT:   data_from_mem = count_q;
                OFF_COMPARE: data_from_mem = compare_q;
                OFF_STATUS:  data_from_mem = {31'h0, status_q};
`endif
                default:     data_from_mem = 32'h0000_0000;
            endcase
        end else begin
            data_from_mem = mem[ram_idx];
        end
    end

endmodule

// File: tb/tb_data_memory_mmio.sv
// ---------------------------------------------------------------------------
// tb_data_memory_mmio
//   Directed self-checking bench for data_memory_mmio (DEPTH_WORDS = 64).
//   Inputs change 1 time unit after a rising edge. Outputs are sampled there
//   too, which is well away from the next edge. Timer checks are built only
//   when DATA_MEMORY_MMIO_TIMER_EN is defined. Otherwise the bench checks
//   that the timer offsets are inert.
// ---------------------------------------------------------------------------
module tb_data_memory_mmio;

    logic        clk = 1'b0;
    logic        reset;
    logic        WE;
    logic [31:0] address;
    logic [31:0] data_to_mem;
    logic [31:0] data_from_mem;
    logic [7:0]  gpio_out;
    logic        irq;

    int n_chk  = 0;
    int n_fail = 0;

    data_memory_mmio #(.DEPTH_WORDS(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .WE            (WE),
        .address       (address),
        .data_to_mem   (data_to_mem),
        .data_from_mem (data_from_mem),
        .gpio_out      (gpio_out),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        address     = a;
        data_to_mem = d;
        WE          = 1'b1;
        tick();
        WE          = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(tag, data_from_mem, exp);
    endtask

    initial begin
        reset = 1'b1; WE = 1'b0; address = 32'h0; data_to_mem = 32'h0;
        #3;
        chk("rst_gpio", {24'h0, gpio_out}, 32'h0);
        chk("rst_irq",  {31'h0, irq}, 32'h0);
`ifdef DATA_MEMORY_MMIO_TIMER_EN
        rd("rst_count",   32'hFFFF_0000, 32'h0);
        rd("rst_compare", 32'hFFFF_0004, 32'hFFFF_FFFF);
`endif

        // Release reset just after an edge, then idle 10 edges.
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) tick();
`ifdef DATA_MEMORY_MMIO_TIMER_EN
        rd("count_after_10", 32'hFFFF_0000, 32'd10);
`else
        rd("count_off_read", 32'hFFFF_0000, 32'h0);
`endif

        // RAM: seed a prior value, then overwrite and check same-cycle/old data.
        wr(32'h0000_0010, 32'h1111_1111);
        address = 32'h0000_0010; data_to_mem = 32'hDEAD_BEEF; WE = 1'b1;
        #1;
        chk("ram_same_cycle_old", data_from_mem, 32'h1111_1111);
        tick();
        WE = 1'b0;
        rd("ram_0x10",      32'h0000_0010, 32'hDEAD_BEEF);
        rd("ram_0x13",      32'h0000_0013, 32'hDEAD_BEEF);
        rd("ram_alias_110", 32'h0000_0110, 32'hDEAD_BEEF);
        rd("ram_alias_hi",  32'hABCD_0010, 32'hDEAD_BEEF);
        wr(32'h0000_00FC, 32'h0BAD_F00D);
        rd("ram_top_word",  32'h0000_01FC, 32'h0BAD_F00D);
        rd("ram_0x10_kept", 32'h0000_0010, 32'hDEAD_BEEF);

        // GPIO: visible only after the edge, upper bits dropped.
        address = 32'hFFFF_000C; data_to_mem = 32'h0000_01A5; WE = 1'b1;
        #1;
        chk("gpio_before_edge", {24'h0, gpio_out}, 32'h0);
        tick();
        WE = 1'b0;
        chk("gpio_out", {24'h0, gpio_out}, 32'hA5);
        rd("gpio_read", 32'hFFFF_000C, 32'h0000_00A5);

        // Unmapped MMIO: reads 0, no side effect on GPIO or aliased RAM word.
        wr(32'hFFFF_0010, 32'hFFFF_FFFF);
        rd("unmapped_read", 32'hFFFF_0010, 32'h0);
        chk("unmapped_gpio", {24'h0, gpio_out}, 32'hA5);
        rd("unmapped_ram", 32'h0000_0010, 32'hDEAD_BEEF);

`ifdef DATA_MEMORY_MMIO_TIMER_EN
        // COUNT load and wrap. COMPARE is still FFFFFFFF, so the wrap matches.
        wr(32'hFFFF_0000, 32'hFFFF_FFFE);
        chk("cnt_wr_val", data_from_mem, 32'hFFFF_FFFE);
        tick();
        chk("cnt_ffff", data_from_mem, 32'hFFFF_FFFF);
        chk("irq_pre_wrap", {31'h0, irq}, 32'h0);
        tick();
        chk("cnt_wrap0", data_from_mem, 32'h0);
        chk("irq_wrap_match", {31'h0, irq}, 32'h1);
        wr(32'hFFFF_0008, 32'h1);
        chk("irq_w1c", {31'h0, irq}, 32'h0);

        // COMPARE = 5 with COUNT cleared.
        wr(32'hFFFF_0000, 32'h0);
        wr(32'hFFFF_0004, 32'd5);
        rd("compare_rd", 32'hFFFF_0004, 32'd5);
        repeat (4) tick();
        rd("count_at_5", 32'hFFFF_0000, 32'd5);
        chk("irq_before_match", {31'h0, irq}, 32'h0);
        tick();
        chk("irq_after_match", {31'h0, irq}, 32'h1);
        rd("status_rd", 32'hFFFF_0008, 32'h1);

        // W1C on a match edge: set wins. Then a plain W1C clears.
        wr(32'hFFFF_0000, 32'd5);
        chk("irq_sticky", {31'h0, irq}, 32'h1);
        wr(32'hFFFF_0008, 32'h1);
        chk("irq_set_wins", {31'h0, irq}, 32'h1);
        wr(32'hFFFF_0008, 32'h1);
        chk("irq_cleared", {31'h0, irq}, 32'h0);

        // COMPARE write at an edge where the new value would match: old COMPARE wins.
        wr(32'hFFFF_0004, 32'd7);
        chk("irq_cmp_old", {31'h0, irq}, 32'h0);
        rd("compare_7", 32'hFFFF_0004, 32'd7);
        tick();
        chk("irq_cmp_after", {31'h0, irq}, 32'h0);

        // Arm irq before the mid-run reset.
        wr(32'hFFFF_0000, 32'd7);
        tick();
        chk("irq_armed", {31'h0, irq}, 32'h1);
`else
        wr(32'hFFFF_0000, 32'd5);
        wr(32'hFFFF_0004, 32'd5);
        wr(32'hFFFF_0008, 32'h1);
        rd("off_count",   32'hFFFF_0000, 32'h0);
        rd("off_compare", 32'hFFFF_0004, 32'h0);
        rd("off_status",  32'hFFFF_0008, 32'h0);
        chk("off_gpio_kept", {24'h0, gpio_out}, 32'hA5);
        repeat (8) tick();
        chk("off_irq", {31'h0, irq}, 32'h0);
`endif

        // Mid-run reset away from any edge.
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_gpio", {24'h0, gpio_out}, 32'h0);
        chk("mid_rst_irq",  {31'h0, irq}, 32'h0);
        rd("mid_rst_ram", 32'h0000_0010, 32'hDEAD_BEEF);
`ifdef DATA_MEMORY_MMIO_TIMER_EN
        rd("mid_rst_count",   32'hFFFF_0000, 32'h0);
        rd("mid_rst_compare", 32'hFFFF_0004, 32'hFFFF_FFFF);
`endif
        // A GPIO write during reset is discarded.
        wr(32'hFFFF_000C, 32'h0000_003C);
        chk("rst_wr_dropped", {24'h0, gpio_out}, 32'h0);
        reset = 1'b0;
        tick();
`ifdef DATA_MEMORY_MMIO_TIMER_EN
        rd("count_first_inc", 32'hFFFF_0000, 32'd1);
`else
        rd("off_count_post", 32'hFFFF_0000, 32'h0);
`endif
        rd("gpio_post_rst", 32'hFFFF_000C, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_mmio.md
DATA_MEMORY_MMIO -- requirements
Module: data_memory_mmio

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, gives the number of 32-bit RAM words; it SHALL be a power of two, 4..4096.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 WE  input  1  write enable from the processor, sampled at the rising clk edge.
REQ-005 address  input  32  byte address from the processor (ALU result).
REQ-006 data_to_mem  input  32  write data.
REQ-007 data_from_mem  output  32  read data, combinational from address and current state.
REQ-008 gpio_out  output  8  registered general-purpose output.
REQ-009 irq  output  1  timer match flag, equal to STATUS[0].

Function
REQ-010 Region decode SHALL be as follows:
- address[31:16] == 16'hFFFF selects MMIO.
- Any other address selects RAM.
REQ-011 RAM index SHALL be address[log2(DEPTH_WORDS)+1:2]; address[1:0] and the upper bits are ignored, so addresses alias modulo DEPTH_WORDS*4.
REQ-012 RAM read SHALL be zero-latency: data_from_mem reflects the addressed word in the same cycle, with no clock edge involved.
REQ-013 RAM write SHALL occur at the rising edge when WE=1; a read of the same word in the write cycle returns the old data, and the new data is visible after the edge.
REQ-014 The MMIO register map SHALL be decoded on address[15:0]:
- 0x0000 COUNT: rw.
- 0x0004 COMPARE: rw.
- 0x0008 STATUS: bit0 = match, write-1-to-clear.
- 0x000C GPIO: rw, bits [7:0]; upper bits read 0.
REQ-015 Unmapped MMIO offsets SHALL read 32'h0, and writes to them SHALL be ignored without side effects.
REQ-016 COUNT SHALL increment by 1 every cycle and wrap from 32'hFFFFFFFF to 0.
REQ-017 A write to COUNT SHALL load data_to_mem at that edge; no increment occurs in that cycle.
REQ-018 At each edge where the pre-edge COUNT equals COMPARE, STATUS[0] SHALL set, and it stays set until cleared.
REQ-019 A W1C write to STATUS bit0 SHALL clear the flag, except when a match occurs at the same edge, in which case set wins.
REQ-020 A write to COMPARE SHALL take effect from the next edge; the match check at the write edge uses the old COMPARE.
REQ-021 gpio_out SHALL equal GPIO[7:0] at all times.
REQ-022 A write to GPIO SHALL be visible on gpio_out after the edge.
REQ-023 The block SHALL have no wait states and no handshake; every access completes in the cycle it is presented.

Reset
REQ-024 Asserting reset SHALL immediately force the following, independent of clk:
- COUNT = 0.
- COMPARE = 32'hFFFFFFFF.
- STATUS = 0 (irq = 0).
- GPIO = 0 (gpio_out = 8'h00).
REQ-025 RAM contents SHALL NOT be affected by reset.
REQ-026 A write presented at an edge while reset is high SHALL be discarded for MMIO registers.
REQ-027 COUNT SHALL first increment at the first rising edge after reset deasserts.

Configuration
REQ-028 Macro DATA_MEMORY_MMIO_TIMER_EN defined: COUNT, COMPARE and STATUS are implemented per REQ-016..REQ-020.
REQ-029 Macro DATA_MEMORY_MMIO_TIMER_EN undefined: no timer registers are synthesised, and:
- Offsets 0x0000, 0x0004 and 0x0008 read 0.
- Writes to those offsets are ignored.
- irq is tied 0.
- RAM and GPIO behaviour is unchanged.

Verification
REQ-030 Write 32'hDEADBEEF to 0x00000010, then read 0x00000010 and 0x00000013 (plus 0x00000110 with DEPTH_WORDS=64) -> all return 32'hDEADBEEF after the write edge; the same-cycle read returns the prior value.
REQ-031 Release reset, idle 10 cycles, read 0xFFFF0000 -> 32'd10.
REQ-032 Write COUNT=32'hFFFFFFFE, read 0xFFFF0000 on the next 3 cycles -> 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0.
REQ-033 Write COMPARE=5 with COUNT reset -> irq rises after the edge where COUNT=5.
REQ-034 Write 1 to 0xFFFF0008 -> irq falls after the edge.
REQ-035 Same W1C write at a match edge -> irq stays 1.
REQ-036 Write 32'h000001A5 to 0xFFFF000C -> gpio_out=8'hA5 and the read returns 32'h000000A5.
REQ-037 Assert reset mid-run -> gpio_out=0 and irq=0 without a clock edge, and RAM word 0x10 still reads 32'hDEADBEEF.
REQ-038 Build without DATA_MEMORY_MMIO_TIMER_EN -> reads of 0xFFFF0000/0xFFFF0004/0xFFFF0008 return 0 and irq stays 0 throughout.
